// File: rtl/addsub_pkg.sv
// Shared constants for the add/sub arbiter.
// FSM state encoding and op-code values.
package addsub_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/add_subbs_verilog.sv
// N-bit ripple-carry adder with carry-in.
// Subtraction is done by the caller (inverted B, Cin=1).
module add_subbs_verilog #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N:0] c;

  assign c[0] = Cin;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_bit
      assign S[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i+1] = (A[i] & B[i]) |
                      (c[i] & (A[i] ^ B[i]));
    end
  endgenerate

  assign Cout = c[N];

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for one shared add/sub unit.
// IDLE accepts, CALC lets the adder settle, HOLD presents the result.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_sub,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [N-1:0] res_s,
  output logic         res_cout,
  output logic         res_ovf
);

  logic [1:0]   state_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         sub_q;
  logic         id_q;
  logic         last_q;
  logic         g0;
  logic         g1;
  logic [N-1:0] b_eff;
  logic [N-1:0] sum;
  logic         cin;
  logic         cout;
  logic         c_msb;

  // last_q=1 means requester 1 won last, so requester 0 wins a tie
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state_q == IDLE) begin
      priority case (1'b1)
        req0_valid && req1_valid: begin
          g0 = last_q;
          g1 = ~last_q;
        end
        req0_valid: g0 = 1'b1;
        req1_valid: g1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_ready = g0;
  assign req1_ready = g1;

  assign cin   = (sub_q == SUB);
  assign b_eff = cin ? ~b_q : b_q;

  add_subbs_verilog #(.N(N)) u_add (
    .A   (a_q),
    .B   (b_eff),
    .Cin (cin),
    .S   (sum),
    .Cout(cout)
  );

  // carry into the MSB recovered from the MSB sum bit
  assign c_msb = a_q[N-1] ^ b_eff[N-1] ^ sum[N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= ADD;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_s     <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (g0 || g1) begin
            a_q     <= g1 ? req1_a : req0_a;
            b_q     <= g1 ? req1_b : req0_b;
            sub_q   <= g1 ? req1_sub : req0_sub;
            id_q    <= g1;
            last_q  <= g1;
            state_q <= CALC;
          end
        end
        CALC: begin
          res_s     <= sum;
          res_cout  <= cout;
          res_ovf   <= c_msb ^ cout;
          res_id    <= id_q;
          res_valid <= 1'b1;
          state_q   <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter (N=8).
// Vector table, directed corner sequences, randomized model check.
module tb_addsub_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [N-1:0] req0_a = '0;
  logic [N-1:0] req0_b = '0;
  logic         req0_sub = 1'b0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [N-1:0] req1_a = '0;
  logic [N-1:0] req1_b = '0;
  logic         req1_sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         res_id;
  logic [N-1:0] res_s;
  logic         res_cout;
  logic         res_ovf;

  int checks = 0;
  int passed = 0;

  addsub_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_sub  (req0_sub),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_sub  (req1_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_s     (res_s),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // {ovf, cout, s} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input bit sub);
    int sa;
    int sb;
    int r;
    int u;
    logic [7:0] s;
    bit c;
    bit o;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      u = int'(a) - int'(b);
      c = (a >= b);
      r = sa - sb;
    end else begin
      u = int'(a) + int'(b);
      c = (u > 255);
      r = sa + sb;
    end
    s = u[7:0];
    o = (r > 127) || (r < -128);
    return {o, c, s};
  endfunction

  function automatic logic [10:0] res_vec();
    return {res_id, res_ovf, res_cout, res_s};
  endfunction

  function automatic logic [1:0] rdy();
    return {req1_ready, req0_ready};
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         r;
    logic [7:0] a;
    logic [7:0] b;
    bit         sub;
    logic [7:0] s;
    bit         cout;
    bit         ovf;
  } vec_t;

  task automatic run_op(input vec_t v);
    @(negedge clk);
    if (v.r) begin
      req1_valid = 1'b1; req1_a = v.a;
      req1_b = v.b; req1_sub = v.sub;
    end else begin
      req0_valid = 1'b1; req0_a = v.a;
      req0_b = v.b; req0_sub = v.sub;
    end
    #1;
    check("vec_grant", rdy(), v.r ? 2'b10 : 2'b01);
    @(negedge clk);
    idle_inputs();
    #1;
    check("vec_calc_rdy", rdy(), 2'b00);
    check("vec_calc_valid", res_valid, 1'b0);
    @(negedge clk);
    check("vec_valid", res_valid, 1'b1);
    check("vec_result", res_vec(),
          {v.r, v.ovf, v.cout, v.s});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("vec_drop", res_valid, 1'b0);
  endtask

  vec_t vecs[8];

  logic [10:0] hold_exp;
  bit          pend[2];
  logic [7:0]  pa[2];
  logic [7:0]  pb[2];
  bit          ps[2];
  bit          last;
  int          ph;
  logic [10:0] exp_res;
  logic [1:0]  eg;

  initial begin
    vecs[0] = '{0, 8'h05, 8'h03, 0, 8'h08, 0, 0};
    vecs[1] = '{1, 8'h7F, 8'h01, 0, 8'h80, 0, 1};
    vecs[2] = '{1, 8'h03, 8'h05, 1, 8'hFE, 0, 0};
    vecs[3] = '{0, 8'hFF, 8'h01, 0, 8'h00, 1, 0};
    vecs[4] = '{0, 8'h80, 8'h01, 1, 8'h7F, 1, 1};
    vecs[5] = '{1, 8'h05, 8'h05, 1, 8'h00, 1, 0};
    vecs[6] = '{0, 8'h80, 8'h80, 0, 8'h00, 1, 1};
    vecs[7] = '{1, 8'h00, 8'h80, 1, 8'h80, 0, 1};

    // reset state
    do_reset();
    #1;
    check("rst_valid", res_valid, 1'b0);
    check("rst_res", res_vec(), 11'h000);
    check("rst_ready", rdy(), 2'b00);

    foreach (vecs[i]) run_op(vecs[i]);

    // both valid, consumer always ready: 0,1,0,1 every 3 cycles
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01;
    req1_valid = 1'b1; req1_a = 8'h20; req1_b = 8'h02;
    req1_sub = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k % 3 == 0)
        check("rr_grant", rdy(),
              ((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      else
        check("rr_gap", rdy(), 2'b00);
      check("rr_valid", res_valid, k % 3 == 2);
      if (k % 3 == 2)
        check("rr_res", res_vec(),
              ((k / 3) % 2 == 0) ? {1'b0, model(8'h10, 8'h01, 0)}
                                 : {1'b1, model(8'h20, 8'h02, 1)});
      @(negedge clk);
    end

    // consumer stalls five cycles in HOLD
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h0E;
    #1;
    check("st_grant", rdy(), 2'b01);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02;
    hold_exp = {1'b0, model(8'h10, 8'h0E, 0)};
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("st_valid", res_valid, 1'b1);
      check("st_res", res_vec(), hold_exp);
      check("st_rdy", rdy(), 2'b00);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    check("st_rdy_last", rdy(), 2'b00);
    @(negedge clk);
    #1;
    check("st_next", rdy(), 2'b10);
    check("st_drop", res_valid, 1'b0);

    // reset during CALC discards the operation
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h11;
    #1;
    check("rc_grant", rdy(), 2'b01);
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rc_res", res_vec(), 11'h000);
    check("rc_valid", res_valid, 1'b0);
    check("rc_rdy", rdy(), 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rc_quiet", res_valid, 1'b0);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rc_tie", rdy(), 2'b01);

    // randomized traffic against the model
    do_reset();
    last = 1'b1;
    ph = 0;
    pend[0] = 0;
    pend[1] = 0;
    exp_res = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1'b1;
          pa[r] = 8'($urandom);
          pb[r] = 8'($urandom);
          ps[r] = 1'($urandom_range(0, 1));
        end
      end
      req0_valid = pend[0]; req0_a = pa[0];
      req0_b = pb[0]; req0_sub = ps[0];
      req1_valid = pend[1]; req1_a = pa[1];
      req1_b = pb[1]; req1_sub = ps[1];
      res_ready = ($urandom_range(0, 2) != 0);
      #1;
      eg = 2'b00;
      if (ph == 0) begin
        if (pend[0] && pend[1]) eg = last ? 2'b01 : 2'b10;
        else if (pend[0]) eg = 2'b01;
        else if (pend[1]) eg = 2'b10;
      end
      check("rnd_grant", rdy(), eg);
      check("rnd_valid", res_valid, ph == 2);
      if (ph == 2) check("rnd_res", res_vec(), exp_res);
      if (ph == 0 && eg != 2'b00) begin
        last = (eg == 2'b10);
        exp_res = {last, model(pa[last], pb[last], ps[last])};
        pend[last] = 1'b0;
        ph = 1;
      end else if (ph == 1) begin
        ph = 2;
      end else if (ph == 2 && res_ready) begin
        ph = 0;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
